// File: rtl/tensor_pkg.sv
// Shared constants, address types and state encoding for the tensor read-side serializer.
package tensor_pkg;

  localparam int N_ROWS  = 8;
  localparam int N_COLS  = 8;
  localparam int N_CHANS = 3;
  localparam int N_ELEMS = N_ROWS * N_COLS * N_CHANS;

  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int CHA_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CHA_W-1:0] cha;
  } tensor_addr_t;

  function automatic logic is_final_addr(tensor_addr_t a);
    return (a.row == ROW_W'(N_ROWS - 1)) &&
           (a.col == COL_W'(N_COLS - 1)) &&
           (a.cha == CHA_W'(N_CHANS - 1));
  endfunction

endpackage

// File: rtl/tensor_serializer_if.sv
// Element stream carrying one tensor value plus its row/col/channel address per beat.
interface tensor_serializer_if
  import tensor_pkg::*;
#(
  parameter int WIDTH = 17
);

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] data_out;
  logic [ROW_W-1:0]        row_addr;
  logic [COL_W-1:0]        col_addr;
  logic [CHA_W-1:0]        cha_addr;
  logic                    last;

  modport master (
    output out_valid, data_out, row_addr, col_addr, cha_addr, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, data_out, row_addr, col_addr, cha_addr, last,
    output out_ready
  );

endinterface

// File: rtl/tensor_addr_counter.sv
// Nested row/col/channel address counter; channel runs fastest and wraps after 2.
module tensor_addr_counter
  import tensor_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output tensor_addr_t addr,
  output tensor_addr_t next_addr,
  output logic         is_last
);

  // next_addr is exposed so the parent can prefetch the following element
  always_comb begin
    next_addr = addr;
    if (addr.cha == CHA_W'(N_CHANS - 1)) begin
      next_addr.cha = '0;
      next_addr.col = addr.col + 1'b1;
      if (addr.col == COL_W'(N_COLS - 1)) begin
        next_addr.row = addr.row + 1'b1;
      end
    end else begin
      next_addr.cha = addr.cha + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (advance) begin
      addr <= next_addr;
    end
  end

  assign is_last = is_final_addr(addr);

endmodule

// File: rtl/tensor_serializer.sv
// Streams an 8x8x3 signed tensor one element per valid/ready beat, channel fastest.
// Define TENSOR_SERIALIZER_SNAPSHOT_EN to capture the tensor on start instead of reading it live.
module tensor_serializer
  import tensor_pkg::*;
#(
  parameter int WIDTH = 17
)(
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic signed [N_ROWS-1:0][N_COLS-1:0][N_CHANS-1:0][WIDTH-1:0] tensor,
  input  logic                                                  start,
  tensor_serializer_if.master                                   strm,
  output logic                                                  busy,
  output logic                                                  done
);

  ser_state_t   state, state_next;
  tensor_addr_t addr, next_addr;
  logic         addr_last;
  logic         accept, handshake, final_hs, advance;

  logic                    out_valid_q, last_q;
  logic signed [WIDTH-1:0] data_q;
  logic signed [WIDTH-1:0] elem_first, elem_next;

  tensor_addr_counter u_addr (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept | final_hs),
    .advance   (advance),
    .addr      (addr),
    .next_addr (next_addr),
    .is_last   (addr_last)
  );

`ifdef TENSOR_SERIALIZER_SNAPSHOT_EN
  logic [N_ROWS-1:0][N_COLS-1:0][N_CHANS-1:0][WIDTH-1:0] snap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
    end else if (accept) begin
      snap <= tensor;
    end
  end

  assign elem_next = snap[next_addr.row][next_addr.col][next_addr.cha];
`else
  assign elem_next = tensor[next_addr.row][next_addr.col][next_addr.cha];
`endif

  // First element comes straight from the input since any snapshot lands on the same edge
  assign elem_first = tensor[0][0][0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = out_valid_q & strm.out_ready;
    final_hs   = handshake & addr_last;
    advance    = handshake & ~addr_last;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (final_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output registers: everything the consumer sees is a flop output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      out_valid_q <= (state_next == STREAM);
      busy        <= (state_next == STREAM);
      done        <= final_hs;
      if (accept) begin
        last_q <= 1'b0;
        data_q <= elem_first;
      end else if (advance) begin
        last_q <= is_final_addr(next_addr);
        data_q <= elem_next;
      end else if (final_hs) begin
        last_q <= 1'b0;
      end
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.data_out  = data_q;
  assign strm.row_addr  = addr.row;
  assign strm.col_addr  = addr.col;
  assign strm.cha_addr  = addr.cha;
  assign strm.last      = last_q;

endmodule

// File: tb/tb_tensor_serializer.sv
// Scoreboard bench for tensor_serializer: reference beats queued per run, monitor pops on handshake.
module tb_tensor_serializer;
  import tensor_pkg::*;

  localparam int W = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic signed [7:0][7:0][2:0][W-1:0] tensor;

  tensor_serializer_if #(.WIDTH(W)) sif ();

  tensor_serializer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .tensor (tensor),
    .start  (start),
    .strm   (sif),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   r;
    logic [2:0]   c;
    logic [1:0]   k;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int    model[8][8][3];
  int    checks = 0, errors = 0;
  int    cyc = 0, beats = 0, done_cnt = 0, first_cyc = 0, done_cyc = 0;
  int    ready_duty = 0;
  logic  prev_stall = 1'b0, prev_valid = 1'b0, last_hs = 1'b0;
  logic [25:0] prev_beat = '0;
  logic [25:0] cur_beat;

  assign cur_beat = {sif.data_out, sif.row_addr, sif.col_addr, sif.cha_addr, sif.last};

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    sif.out_ready = ($urandom_range(0, 99) < ready_duty);
  end

  // Monitor: sample mid-cycle, pop one reference beat per handshake
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      last_hs    = 1'b0;
    end else begin
      if (sif.out_valid) begin
        chk("cha_range", 64'(sif.cha_addr == 2'd3), 64'd0);
        if (prev_stall) chk("hold_stable", 64'(cur_beat), 64'(prev_beat));
        if (!prev_valid) first_cyc = cyc;
        if (sif.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'(cur_beat), 64'({e.d, e.r, e.c, e.k, e.l}));
            beats++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_idle", 64'({sif.out_valid, busy}), 64'd0);
        chk("done_after_last", 64'(last_hs), 64'd1);
      end
      prev_stall = sif.out_valid & ~sif.out_ready;
      prev_valid = sif.out_valid;
      prev_beat  = cur_beat;
      last_hs    = sif.out_valid & sif.out_ready & sif.last;
    end
  end

  // mode 0: i*24+j*3+k, 1: random, 2: all -1
  task automatic load_tensor(int mode);
    int v;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 3; k++) begin
          if (mode == 0)      v = i * 24 + j * 3 + k;
          else if (mode == 1) v = int'($urandom);
          else                v = -1;
          model[i][j][k]  = v;
          tensor[i][j][k] = W'(v);
        end
  endtask

  task automatic set_tensor_const(int v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 3; k++)
          tensor[i][j][k] = W'(v);
  endtask

  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 3; k++) begin
          b.d = W'(model[i][j][k]);
          b.r = 3'(i);
          b.c = 3'(j);
          b.k = 2'(k);
          b.l = (i == 7) && (j == 7) && (k == 2);
          exp_q.push_back(b);
        end
  endtask

  task automatic run(int duty, bit inject, bit overwrite);
    int d0, k, s_edge;
    bit fin;
    d0  = done_cnt;
    fin = 1'b0;
    k   = 0;
    push_expected();
    ready_duty = duty;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_edge = cyc;
    if (overwrite) set_tensor_const(5);
    while (!fin && k < 6000) begin
      @(posedge clk); #1;
      k = cyc - s_edge;
      start = inject && (k == 40 || k == 191);
      if (done_cnt != d0) fin = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", 64'(fin), 64'd1);
    if (duty == 100) begin
      chk("start_latency", 64'(first_cyc - (s_edge - 1)), 64'd1);
      chk("done_cycle", 64'(done_cyc - (s_edge - 1)), 64'd193);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("single_done", 64'(done_cnt - d0), 64'd1);
    chk("idle_after", 64'({sif.out_valid, busy, done}), 64'd0);
    chk("all_beats", 64'(exp_q.size()), 64'd0);
    if (!fin) begin
      rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
    end
    exp_q.delete();
  endtask

  task automatic abort_midstream();
    int b0, d0, n;
    load_tensor(0);
    push_expected();
    ready_duty = 100;
    b0 = beats;
    d0 = done_cnt;
    n  = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (beats - b0 < 50 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1 rst = 1'b0;
    #1;
    chk("reached_beat50", 64'(beats - b0 >= 50), 64'd1);
    chk("abort_outputs", 64'({sif.out_valid, sif.data_out, sif.row_addr, sif.col_addr,
                              sif.cha_addr, sif.last, busy, done}), 64'd0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    ready_duty = 100;
    load_tensor(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({sif.out_valid, sif.data_out, sif.row_addr, sif.col_addr,
                            sif.cha_addr, sif.last, busy, done}), 64'd0);
    rst = 1'b1;
    repeat (6) @(posedge clk);

    run(100, 1'b0, 1'b0);
    load_tensor(1);
    run(30, 1'b0, 1'b0);
    load_tensor(2);
    run(100, 1'b0, 1'b0);
    load_tensor(1);
    run(100, 1'b1, 1'b0);
    abort_midstream();
    load_tensor(0);
    run(100, 1'b0, 1'b0);
`ifdef TENSOR_SERIALIZER_SNAPSHOT_EN
    load_tensor(0);
    run(100, 1'b0, 1'b1);
`endif
    load_tensor(1);
    run(60, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tensor_serializer.md
Name: tensor_serializer

Overview:
Reads back a complete 8x8x3 signed tensor, as held by the tensor write-side storage, and streams it out one element per beat over a valid/ready interface. Each beat carries the element plus its row/col/channel address. This is the read-side counterpart of the address-driven tensor writer. It feeds downstream compute or a transmit link once a tensor is complete.

Parameters:
- WIDTH, 17, bit width of each signed tensor element and of data_out.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tensor  in  signed WIDTH x [7:0][7:0][2:0]  source tensor (8 rows, 8 cols, 3 channels).
- start  in  1  single-cycle request to stream the tensor; honoured only in IDLE.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  beat present on data_out/addresses.
- data_out  out  signed WIDTH  element value.
- row_addr  out  3  row index of current beat.
- col_addr  out  3  column index of current beat.
- cha_addr  out  2  channel index of current beat (0..2 only).
- last  out  1  high with the final beat (row 7, col 7, cha 2).
- busy  out  1  high while in STREAM.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid=0, data_out=0, row/col/cha_addr=0, last=0, busy=0, done=0.
- FSM states: IDLE, STREAM.
  - IDLE -> STREAM on start=1.
  - STREAM -> IDLE on a handshake (out_valid & out_ready) while last=1.
- Start latency: start sampled high in cycle N -> out_valid=1 in cycle N+1, carrying tensor[0][0][0] at address (0,0,0).
- Order: channel fastest, then column, then row.
  - cha 0->1->2, then wraps to 0 with col+1.
  - col 7 wrapping to 0 advances row+1.
  - cha_addr never takes the value 3.
  - Exactly 192 beats per run.
- Handshake:
  - A beat transfers when out_valid & out_ready at a rising edge; the next element appears the following cycle.
  - Zero bubbles when out_ready is held high: one beat per cycle.
  - While out_valid=1 and out_ready=0, data_out, addresses and last hold stable.
  - out_valid never drops mid-stream except through reset.
- All outputs are registered; there is no combinational path from out_ready to any output.
- done: pulses high for exactly one cycle, the cycle after the last handshake; out_valid=0 and busy=0 in that same cycle.
- start while busy=1 is ignored, with no restart and no queueing.
- start in the same cycle as the final handshake is ignored; a new start is required once in IDLE.
- Reset asserted mid-stream aborts immediately: no done pulse, all outputs return to reset values.
- Arithmetic: data_out is a straight copy of the element; no sign extension or truncation.

Optional Feature:
- Macro: TENSOR_SERIALIZER_SNAPSHOT_EN.
- Defined:
  - The full tensor is captured into an internal register array on the cycle start is accepted.
  - Streamed values come from the snapshot, so upstream may overwrite tensor immediately after start.
  - Snapshot is cleared to 0 on reset.
- Undefined:
  - No snapshot storage; data_out is registered from the live tensor input at the current address.
  - Upstream must hold tensor stable from start until done.

Decomposition:
- Shared package tensor_pkg:
  - constants N_ROWS=8, N_COLS=8, N_CHANS=3, N_ELEMS=192;
  - address widths ROW_W=3, COL_W=3, CHA_W=2;
  - typedef enum ser_state_t {IDLE, STREAM};
  - typedef struct tensor_addr_t {row, col, cha}.
- One sub-module, tensor_addr_counter:
  - nested row/col/cha counter with clear, advance enable, channel wrap at 2, and an is_last flag.

Test Plan:
- Reset mid-stream: assert rst=0 at beat 50 -> all outputs 0 immediately; no done pulse; next start restarts at (0,0,0).
- Full-rate stream: tensor[i][j][k]=i*24+j*3+k, out_ready=1, start at cycle 10 -> out_valid from cycle 11, 192 consecutive beats with data 0..191 in order, last on beat 192 at addr (7,7,2), done at cycle 203.
- Backpressure: random out_ready at 30% duty -> data/addr/last stable whenever valid&!ready, still exactly 192 beats in order, cha_addr never 3.
- Negative values: all elements = -1 (17'h1FFFF) -> every data_out = 17'h1FFFF, no width change.
- Start while busy: pulse start again at beat 40 and in the final-handshake cycle -> no restart, single done pulse, then IDLE.
- Snapshot feature (TENSOR_SERIALIZER_SNAPSHOT_EN defined): overwrite tensor with all 5 one cycle after start -> stream still outputs the original 0..191.
